// File: rtl/alu_issue_if.sv
// Bundle between the fetch stage, the issue unit and the combinational ALU.
// The slave modport is the issue unit; master is the fetch/ALU/debug side.
interface alu_issue_if;
   // Instruction handshake: a word transfers on a rising edge where
   // instr_valid and instr_ready are both high. The source holds instr
   // stable while instr_valid is high and instr_ready is low.
   logic        instr_valid;
   logic        instr_ready;
   logic [15:0] instr;
   logic [3:0]  alu_operation;
   logic [15:0] alu_op1;
   logic [15:0] alu_op2;
   logic [15:0] alu_res;
   logic        alu_zero;
   logic        alu_error;
   logic        done_valid;
   logic        done_zero;
   logic        done_error;
   logic [2:0]  dbg_addr;
   logic [15:0] dbg_data;
   logic [1:0]  dbg_state;

   modport master (
      output instr_valid, instr, alu_res, alu_zero, alu_error, dbg_addr,
      input  instr_ready, alu_operation, alu_op1, alu_op2,
             done_valid, done_zero, done_error, dbg_data, dbg_state
   );

   modport slave (
      input  instr_valid, instr, alu_res, alu_zero, alu_error, dbg_addr,
      output instr_ready, alu_operation, alu_op1, alu_op2,
             done_valid, done_zero, done_error, dbg_data, dbg_state
   );
endinterface

// File: rtl/alu_issue_unit.sv
// Issue/writeback controller for the 16-bit ALU with an 8x16 register file.
// Define ALU_ISSUE_FASTWB_EN to merge EXEC and WB (3-cycle throughput).
module alu_issue_unit (
   input  logic        clk,
   input  logic        rst,
   alu_issue_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      READ = 2'd1,
`ifdef ALU_ISSUE_FASTWB_EN
      EXEC = 2'd2
`else
      EXEC = 2'd2,
      WB   = 2'd3
`endif
   } state_t;

   state_t      state_q, state_d;
   logic [15:0] instr_q;
   logic [3:0]  op_q;
   logic [15:0] op1_q, op2_q;
   logic [2:0]  rd_q;
   logic        fault_q;
   logic        done_valid_q, done_zero_q, done_error_q;
   logic [15:0] rf [8];

   logic [3:0]  dec_op;
   logic [15:0] dec_op1, dec_op2;
   logic        dec_fault;
   logic [15:0] rs1_val, rs2_val;

   logic        wb_fire;
   logic [15:0] wb_res;
   logic        wb_zero, wb_err;

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (bus.instr_valid) state_d = READ;
         READ:    state_d = EXEC;
`ifdef ALU_ISSUE_FASTWB_EN
         EXEC:    state_d = IDLE;
`else
         EXEC:    state_d = WB;
         WB:      state_d = IDLE;
`endif
         default: state_d = IDLE;
      endcase
   end

   assign rs1_val = rf[instr_q[8:6]];
   assign rs2_val = rf[instr_q[5:3]];

   // Faulting words drive a harmless AND of zeros so the ALU sees a clean op.
   always_comb begin
      dec_op    = 4'd0;
      dec_op1   = 16'd0;
      dec_op2   = 16'd0;
      dec_fault = 1'b0;
      if (instr_q[15:12] == 4'hF) begin
         dec_op  = 4'h8;
         dec_op1 = {7'd0, instr_q[8:0]};
      end else if (instr_q[15:12] > 4'hA) begin
         dec_fault = 1'b1;
      end else if (instr_q[15:12] == 4'hA && rs2_val == 16'd0) begin
         dec_fault = 1'b1;
      end else begin
         dec_op  = instr_q[15:12];
         dec_op1 = rs1_val;
         dec_op2 = rs2_val;
      end
   end

`ifdef ALU_ISSUE_FASTWB_EN
   assign wb_fire = (state_q == EXEC);
   assign wb_res  = bus.alu_res;
   assign wb_zero = bus.alu_zero;
   assign wb_err  = fault_q | bus.alu_error;
`else
   logic [15:0] res_q;
   logic        zero_q, alu_err_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         res_q     <= 16'd0;
         zero_q    <= 1'b0;
         alu_err_q <= 1'b0;
      end else if (state_q == EXEC) begin
         res_q     <= bus.alu_res;
         zero_q    <= bus.alu_zero;
         alu_err_q <= bus.alu_error;
      end
   end

   assign wb_fire = (state_q == WB);
   assign wb_res  = res_q;
   assign wb_zero = zero_q;
   assign wb_err  = fault_q | alu_err_q;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         instr_q      <= 16'd0;
         op_q         <= 4'd0;
         op1_q        <= 16'd0;
         op2_q        <= 16'd0;
         rd_q         <= 3'd0;
         fault_q      <= 1'b0;
         done_valid_q <= 1'b0;
         done_zero_q  <= 1'b0;
         done_error_q <= 1'b0;
         for (int i = 0; i < 8; i++) rf[i] <= 16'd0;
      end else begin
         done_valid_q <= 1'b0;
         if (state_q == IDLE && bus.instr_valid) instr_q <= bus.instr;
         if (state_q == READ) begin
            op_q    <= dec_op;
            op1_q   <= dec_op1;
            op2_q   <= dec_op2;
            fault_q <= dec_fault;
            rd_q    <= instr_q[11:9];
         end
         // r0 stays zero: its write is dropped but completion still reports.
         if (wb_fire) begin
            if (!wb_err && rd_q != 3'd0) rf[rd_q] <= wb_res;
            done_valid_q <= 1'b1;
            done_error_q <= wb_err;
            done_zero_q  <= wb_zero & ~wb_err;
         end
      end
   end

   assign bus.instr_ready   = (state_q == IDLE);
   assign bus.alu_operation = op_q;
   assign bus.alu_op1       = op1_q;
   assign bus.alu_op2       = op2_q;
   assign bus.done_valid    = done_valid_q;
   assign bus.done_zero     = done_zero_q;
   assign bus.done_error    = done_error_q;
   assign bus.dbg_data      = (bus.dbg_addr == 3'd0) ? 16'd0 : rf[bus.dbg_addr];
   assign bus.dbg_state     = state_q;

endmodule
